// File: rtl/sram_arbiter_if.sv
// Bundle of the core, host and SRAM-side signals around sram_arbiter.
// master = requesters plus the SRAM macro; slave = the arbiter itself.
interface sram_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_ready;
    logic              core_stall;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] host_rdata;
    logic              host_ready;

    logic              sram_en;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output host_req, host_we, host_addr, host_wdata,
        output sram_rdata,
        input  core_rdata, core_ready, core_stall,
        input  host_rdata, host_ready,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        input  sram_rdata,
        output core_rdata, core_ready, core_stall,
        output host_rdata, host_ready,
        output sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Shares the single-port data SRAM between the core load/store path and the host/debug port.
// One access per two cycles: grant and drive the SRAM in IDLE, return data and ready in RESP.
module sram_arbiter #(
    parameter int ADDR_W        = 10,
    parameter int DATA_W        = 32,
    parameter bit CORE_PRIORITY = 1'b0
) (
    input  logic          clk,
    input  logic          rstn,
    sram_arbiter_if.slave arb
);

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic              ownerHost_q, ownerHost_d;
    logic              lastHost_q, lastHost_d;
    logic              opWrite_q, opWrite_d;
    logic [DATA_W-1:0] coreHeld_q, coreHeld_d;
    logic [DATA_W-1:0] hostHeld_q, hostHeld_d;

    logic              grantCore;
    logic              grantHost;
    logic              sramEn;
    logic              sramWe;
    logic [ADDR_W-1:0] sramAddr;
    logic [DATA_W-1:0] sramWdata;
    logic              coreReady;
    logic              hostReady;
    logic [DATA_W-1:0] coreRdata;
    logic [DATA_W-1:0] hostRdata;

    always_comb begin
        state_d     = state_q;
        ownerHost_d = ownerHost_q;
        lastHost_d  = lastHost_q;
        opWrite_d   = opWrite_q;
        coreHeld_d  = coreHeld_q;
        hostHeld_d  = hostHeld_q;
        grantCore   = 1'b0;
        grantHost   = 1'b0;
        sramEn      = 1'b0;
        sramWe      = 1'b0;
        sramAddr    = '0;
        sramWdata   = '0;
        coreReady   = 1'b0;
        hostReady   = 1'b0;
        coreRdata   = coreHeld_q;
        hostRdata   = hostHeld_q;

        case (state_q)
            IDLE: begin
                // On a conflict the core wins if prioritised or if the host had the last grant.
                if (arb.core_req && (!arb.host_req || CORE_PRIORITY || lastHost_q)) begin
                    grantCore = 1'b1;
                end else if (arb.host_req) begin
                    grantHost = 1'b1;
                end

                if (grantCore || grantHost) begin
                    sramEn      = 1'b1;
                    sramWe      = grantHost ? arb.host_we    : arb.core_we;
                    sramAddr    = grantHost ? arb.host_addr  : arb.core_addr;
                    sramWdata   = grantHost ? arb.host_wdata : arb.core_wdata;
                    state_d     = RESP;
                    ownerHost_d = grantHost;
                    lastHost_d  = grantHost;
                    opWrite_d   = sramWe;
                end
            end

            RESP: begin
                state_d = IDLE;
                // Read data is forwarded straight from the SRAM and captured for later cycles.
                if (ownerHost_q) begin
                    hostReady = 1'b1;
                    if (!opWrite_q) begin
                        hostRdata  = arb.sram_rdata;
                        hostHeld_d = arb.sram_rdata;
                    end
                end else begin
                    coreReady = 1'b1;
                    if (!opWrite_q) begin
                        coreRdata  = arb.sram_rdata;
                        coreHeld_d = arb.sram_rdata;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            ownerHost_q <= 1'b0;
            lastHost_q  <= 1'b1;
            opWrite_q   <= 1'b0;
            coreHeld_q  <= '0;
            hostHeld_q  <= '0;
        end else begin
            state_q     <= state_d;
            ownerHost_q <= ownerHost_d;
            lastHost_q  <= lastHost_d;
            opWrite_q   <= opWrite_d;
            coreHeld_q  <= coreHeld_d;
            hostHeld_q  <= hostHeld_d;
        end
    end

    // IDLE drives the SRAM from live requests, so outputs are forced quiet while reset is held.
    assign arb.sram_en    = rstn & sramEn;
    assign arb.sram_we    = rstn & sramWe;
    assign arb.sram_addr  = rstn ? sramAddr  : '0;
    assign arb.sram_wdata = rstn ? sramWdata : '0;

    assign arb.core_ready = coreReady;
    assign arb.host_ready = hostReady;
    assign arb.core_rdata = coreRdata;
    assign arb.host_rdata = hostRdata;
    assign arb.core_stall = rstn & arb.core_req & ~coreReady;

endmodule
